// File: rtl/traffic_control_multi.sv
// Round-robin intersection controller for NUM_DIRS approaches with all-red clearance,
// latched pedestrian walk and emergency preemption that never cuts yellow or clearance.
module traffic_control_multi #(
  parameter int NUM_DIRS     = 4,
  parameter int CNT_W        = 8,
  parameter int GREEN_TIME   = 10,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 2,
  parameter int PED_TIME     = 5,
  parameter int EMG_MIN_TIME = 6
) (
  input  logic                        clk,
  input  logic                        rst_a,
  input  logic                        ped_request,
  input  logic [NUM_DIRS-1:0]         emergency_dir,
  output logic [3*NUM_DIRS-1:0]       lights,
  output logic                        ped_walk,
  output logic                        emg_active,
  output logic [$clog2(NUM_DIRS)-1:0] active_dir
);

  localparam int DIR_W = $clog2(NUM_DIRS);

  localparam logic [CNT_W-1:0] GREEN_LAST   = CNT_W'(GREEN_TIME - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_TIME - 1);
  localparam logic [CNT_W-1:0] PED_LAST     = CNT_W'(PED_TIME - 1);
  localparam logic [CNT_W-1:0] EMG_LAST     = CNT_W'(EMG_MIN_TIME - 1);

  typedef enum logic [2:0] {
    S_GREEN,
    S_YELLOW,
    S_ALL_RED,
    S_PED_WALK,
    S_EMG_GREEN
  } state_e;

  state_e             state_q, state_d;
  logic [DIR_W-1:0]   cur_dir_q, cur_dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ped_pending_q, ped_pending_d;

  logic               emg_req;
  logic [DIR_W-1:0]   emg_sel;
  logic [DIR_W-1:0]   next_dir;
  logic [2:0]         lamp;

  // Lowest-numbered requesting approach wins the emergency arbitration.
  always_comb begin
    emg_sel = '0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (emergency_dir[i]) emg_sel = DIR_W'(i);
    end
  end

  assign emg_req  = |emergency_dir;
  assign next_dir = (cur_dir_q == DIR_W'(NUM_DIRS - 1)) ? '0 : cur_dir_q + DIR_W'(1);

  always_comb begin
    state_d       = state_q;
    cur_dir_d     = cur_dir_q;
    cnt_d         = cnt_q + CNT_W'(1);
    ped_pending_d = ped_pending_q | (ped_request && (state_q != S_PED_WALK));

    case (state_q)
      S_GREEN: begin
        if (emg_req && (emg_sel == cur_dir_q)) state_d = S_EMG_GREEN;
        else if (emg_req || (cnt_q == GREEN_LAST)) state_d = S_YELLOW;
      end
      S_YELLOW: begin
        if (cnt_q == YELLOW_LAST) state_d = S_ALL_RED;
      end
      S_ALL_RED: begin
        if (cnt_q == ALL_RED_LAST) begin
          if (emg_req) begin
            state_d   = S_EMG_GREEN;
            cur_dir_d = emg_sel;
          end else if (ped_pending_q) begin
            state_d = S_PED_WALK;
          end else begin
            state_d   = S_GREEN;
            cur_dir_d = next_dir;
          end
        end
      end
      S_PED_WALK: begin
        // An aborted walk stays pending so it is served again after the emergency.
        if (emg_req) begin
          state_d       = S_ALL_RED;
          ped_pending_d = 1'b1;
        end else if (cnt_q == PED_LAST) begin
          state_d = S_ALL_RED;
        end
      end
      S_EMG_GREEN: begin
        if (!emergency_dir[cur_dir_q] && (cnt_q >= EMG_LAST)) state_d = S_YELLOW;
        else if (cnt_q >= EMG_LAST) cnt_d = cnt_q;
      end
      default: state_d = S_GREEN;
    endcase

    if (state_d != state_q) cnt_d = '0;
    if ((state_d == S_PED_WALK) && (state_q != S_PED_WALK)) ped_pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q       <= S_GREEN;
      cur_dir_q     <= '0;
      cnt_q         <= '0;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_dir_q     <= cur_dir_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  always_comb begin
    lamp       = 3'b001;
    ped_walk   = 1'b0;
    emg_active = 1'b0;
    case (state_q)
      S_GREEN:     lamp = 3'b100;
      S_EMG_GREEN: begin
        lamp       = 3'b100;
        emg_active = 1'b1;
      end
      S_YELLOW:    lamp = 3'b010;
      S_PED_WALK:  ped_walk = 1'b1;
      default:     lamp = 3'b001;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_DIRS; i++) begin
      lights[3*i +: 3] = (DIR_W'(i) == cur_dir_q) ? lamp : 3'b001;
    end
  end

  assign active_dir = cur_dir_q;

endmodule

// File: tb/tb_traffic_control_multi.sv
// Checks a 4-way and a 3-way controller against a phase/time-remaining model,
// using a table of scenario checkpoints, hand-written corner sequences and random traffic.
module tb_traffic_control_multi;

  localparam int PH_GREEN  = 0;
  localparam int PH_YELLOW = 1;
  localparam int PH_CLEAR  = 2;
  localparam int PH_WALK   = 3;
  localparam int PH_EMG    = 4;

  localparam int C_RED    = 0;
  localparam int C_GREEN  = 1;
  localparam int C_YELLOW = 2;

  typedef struct {
    int phase;
    int dir;
    int left;
    bit ped;
  } model_t;

  typedef struct {
    int         pedCycle;
    logic [3:0] emgA;
    int         startA;
    int         lenA;
    logic [3:0] emgB;
    int         startB;
    int         lenB;
    int         checkCycle;
    int         expColor;
    int         expDir;
    bit         expWalk;
    bit         expEmg;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_a;
  logic       ped_request;
  logic [3:0] emergency_dir;

  logic [11:0] lights4;
  logic        ped_walk4, emg_active4;
  logic [1:0]  active_dir4;
  logic [8:0]  lights3;
  logic        ped_walk3, emg_active3;
  logic [1:0]  active_dir3;

  int     checks = 0;
  int     errors = 0;
  int     cycle;
  model_t m4, m3;
  vec_t   vecs[$];

  always #5 clk = ~clk;

  traffic_control_multi #(.NUM_DIRS(4)) dut4 (
    .clk(clk), .rst_a(rst_a), .ped_request(ped_request), .emergency_dir(emergency_dir),
    .lights(lights4), .ped_walk(ped_walk4), .emg_active(emg_active4), .active_dir(active_dir4)
  );

  traffic_control_multi #(.NUM_DIRS(3)) dut3 (
    .clk(clk), .rst_a(rst_a), .ped_request(ped_request), .emergency_dir(emergency_dir[2:0]),
    .lights(lights3), .ped_walk(ped_walk3), .emg_active(emg_active3), .active_dir(active_dir3)
  );

  function automatic int duration(int ph);
    case (ph)
      PH_GREEN:  return 10;
      PH_YELLOW: return 3;
      PH_CLEAR:  return 2;
      PH_WALK:   return 5;
      default:   return 6;
    endcase
  endfunction

  function automatic model_t enterPhase(model_t m, int ph, int d);
    model_t r = m;
    r.phase = ph;
    r.dir   = d;
    r.left  = duration(ph);
    return r;
  endfunction

  function automatic model_t modelReset();
    model_t r;
    r.phase = PH_GREEN;
    r.dir   = 0;
    r.left  = duration(PH_GREEN);
    r.ped   = 1'b0;
    return r;
  endfunction

  // One clock of the intersection: "left" is how many cycles of the current phase remain.
  function automatic model_t modelStep(model_t m, int n, bit pedReq, logic [7:0] emg);
    model_t r = m;
    int low = -1;
    bit any;
    for (int i = n - 1; i >= 0; i--) if (emg[i]) low = i;
    any = (low >= 0);
    if (pedReq && m.phase != PH_WALK) r.ped = 1'b1;
    case (m.phase)
      PH_GREEN: begin
        if (any && low == m.dir) r = enterPhase(r, PH_EMG, m.dir);
        else if (any || m.left == 1) r = enterPhase(r, PH_YELLOW, m.dir);
        else r.left--;
      end
      PH_YELLOW: begin
        if (m.left == 1) r = enterPhase(r, PH_CLEAR, m.dir);
        else r.left--;
      end
      PH_CLEAR: begin
        if (m.left == 1) begin
          if (any) r = enterPhase(r, PH_EMG, low);
          else if (m.ped) begin
            r = enterPhase(r, PH_WALK, m.dir);
            r.ped = 1'b0;
          end else r = enterPhase(r, PH_GREEN, (m.dir + 1) % n);
        end else r.left--;
      end
      PH_WALK: begin
        if (any) begin
          r = enterPhase(r, PH_CLEAR, m.dir);
          r.ped = 1'b1;
        end else if (m.left == 1) r = enterPhase(r, PH_CLEAR, m.dir);
        else r.left--;
      end
      default: begin
        if (!emg[m.dir] && m.left == 1) r = enterPhase(r, PH_YELLOW, m.dir);
        else if (m.left > 1) r.left--;
      end
    endcase
    return r;
  endfunction

  function automatic logic [23:0] lampVector(int color, int dir, int n);
    logic [23:0] v = '0;
    for (int i = 0; i < n; i++) begin
      if (i == dir && color == C_GREEN) v[3*i +: 3] = 3'b100;
      else if (i == dir && color == C_YELLOW) v[3*i +: 3] = 3'b010;
      else v[3*i +: 3] = 3'b001;
    end
    return v;
  endfunction

  function automatic int modelColor(model_t m);
    if (m.phase == PH_GREEN || m.phase == PH_EMG) return C_GREEN;
    if (m.phase == PH_YELLOW) return C_YELLOW;
    return C_RED;
  endfunction

  task automatic checkOutput(input string tag);
    logic [23:0] e4, e3;
    e4 = lampVector(modelColor(m4), m4.dir, 4);
    e3 = lampVector(modelColor(m3), m3.dir, 3);
    checks++;
    if (lights4 !== e4[11:0] || ped_walk4 !== (m4.phase == PH_WALK) ||
        emg_active4 !== (m4.phase == PH_EMG) || active_dir4 !== 2'(m4.dir)) begin
      errors++;
      $display("[TB] FAIL %s dut4 cycle %0d: got lights=%b walk=%b emg=%b dir=%0d, want lights=%b walk=%b emg=%b dir=%0d",
               tag, cycle, lights4, ped_walk4, emg_active4, active_dir4,
               e4[11:0], m4.phase == PH_WALK, m4.phase == PH_EMG, m4.dir);
    end
    checks++;
    if (lights3 !== e3[8:0] || ped_walk3 !== (m3.phase == PH_WALK) ||
        emg_active3 !== (m3.phase == PH_EMG) || active_dir3 !== 2'(m3.dir)) begin
      errors++;
      $display("[TB] FAIL %s dut3 cycle %0d: got lights=%b walk=%b emg=%b dir=%0d, want lights=%b walk=%b emg=%b dir=%0d",
               tag, cycle, lights3, ped_walk3, emg_active3, active_dir3,
               e3[8:0], m3.phase == PH_WALK, m3.phase == PH_EMG, m3.dir);
    end
  endtask

  // Drives one cycle of inputs, advances both models across the edge and compares.
  task automatic applyStimulus(input bit rst, input bit ped, input logic [3:0] emg, input string tag);
    rst_a         = rst;
    ped_request   = ped;
    emergency_dir = emg;
    @(posedge clk);
    if (rst) begin
      m4 = modelReset();
      m3 = modelReset();
    end else begin
      m4 = modelStep(m4, 4, ped, {4'b0, emg});
      m3 = modelStep(m3, 3, ped, {5'b0, emg[2:0]});
    end
    #1;
    cycle = rst ? 0 : cycle + 1;
    checkOutput(tag);
  endtask

  task automatic resetDut(input string tag);
    applyStimulus(1'b1, 1'b0, 4'b0, tag);
  endtask

  task automatic checkDirected(input string tag, input int color, input int dir, input bit walk, input bit emg);
    logic [23:0] e;
    e = lampVector(color, dir, 4);
    checks++;
    if (lights4 !== e[11:0] || ped_walk4 !== walk || emg_active4 !== emg || active_dir4 !== 2'(dir)) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got lights=%b walk=%b emg=%b dir=%0d, want lights=%b walk=%b emg=%b dir=%0d",
               tag, cycle, lights4, ped_walk4, emg_active4, active_dir4, e[11:0], walk, emg, dir);
    end
  endtask

  task automatic check3Way(input string tag, input int color, input int dir);
    logic [23:0] e;
    e = lampVector(color, dir, 3);
    checks++;
    if (lights3 !== e[8:0] || active_dir3 !== 2'(dir)) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got lights=%b dir=%0d, want lights=%b dir=%0d",
               tag, cycle, lights3, active_dir3, e[8:0], dir);
    end
  endtask

  function automatic vec_t mkVec(int pc, logic [3:0] ea, int sa, int la, logic [3:0] eb, int sb, int lb,
                                 int cc, int col, int d, bit w, bit e);
    vec_t v;
    v.pedCycle = pc; v.emgA = ea; v.startA = sa; v.lenA = la;
    v.emgB = eb; v.startB = sb; v.lenB = lb;
    v.checkCycle = cc; v.expColor = col; v.expDir = d; v.expWalk = w; v.expEmg = e;
    return v;
  endfunction

  initial begin
    rst_a         = 1'b1;
    ped_request   = 1'b0;
    emergency_dir = 4'b0;
    cycle         = 0;
    m4            = modelReset();
    m3            = modelReset();

    // Idle rotation
    vecs.push_back(mkVec(-1, 4'b0, 0, 0, 4'b0, 0, 0,  0, C_GREEN,  0, 0, 0));
    vecs.push_back(mkVec(-1, 4'b0, 0, 0, 4'b0, 0, 0,  9, C_GREEN,  0, 0, 0));
    vecs.push_back(mkVec(-1, 4'b0, 0, 0, 4'b0, 0, 0, 10, C_YELLOW, 0, 0, 0));
    vecs.push_back(mkVec(-1, 4'b0, 0, 0, 4'b0, 0, 0, 13, C_RED,    0, 0, 0));
    vecs.push_back(mkVec(-1, 4'b0, 0, 0, 4'b0, 0, 0, 15, C_GREEN,  1, 0, 0));
    vecs.push_back(mkVec(-1, 4'b0, 0, 0, 4'b0, 0, 0, 60, C_GREEN,  0, 0, 0));
    // Pedestrian pulse at cycle 4
    vecs.push_back(mkVec( 4, 4'b0, 0, 0, 4'b0, 0, 0, 15, C_RED,    0, 1, 0));
    vecs.push_back(mkVec( 4, 4'b0, 0, 0, 4'b0, 0, 0, 19, C_RED,    0, 1, 0));
    vecs.push_back(mkVec( 4, 4'b0, 0, 0, 4'b0, 0, 0, 20, C_RED,    0, 0, 0));
    vecs.push_back(mkVec( 4, 4'b0, 0, 0, 4'b0, 0, 0, 22, C_GREEN,  1, 0, 0));
    // Emergency on approach 2 truncates dir0 green
    vecs.push_back(mkVec(-1, 4'b0100, 3, 20, 4'b0, 0, 0,  4, C_YELLOW, 0, 0, 0));
    vecs.push_back(mkVec(-1, 4'b0100, 3, 20, 4'b0, 0, 0,  7, C_RED,    0, 0, 0));
    vecs.push_back(mkVec(-1, 4'b0100, 3, 20, 4'b0, 0, 0,  9, C_GREEN,  2, 0, 1));
    vecs.push_back(mkVec(-1, 4'b0100, 3, 20, 4'b0, 0, 0, 23, C_GREEN,  2, 0, 1));
    vecs.push_back(mkVec(-1, 4'b0100, 3, 20, 4'b0, 0, 0, 24, C_YELLOW, 2, 0, 0));
    vecs.push_back(mkVec(-1, 4'b0100, 3, 20, 4'b0, 0, 0, 29, C_GREEN,  3, 0, 0));
    // One-cycle emergency on the already-green approach: minimum hold
    vecs.push_back(mkVec(-1, 4'b0001, 2, 1, 4'b0, 0, 0,  3, C_GREEN,  0, 0, 1));
    vecs.push_back(mkVec(-1, 4'b0001, 2, 1, 4'b0, 0, 0,  8, C_GREEN,  0, 0, 1));
    vecs.push_back(mkVec(-1, 4'b0001, 2, 1, 4'b0, 0, 0,  9, C_YELLOW, 0, 0, 0));
    vecs.push_back(mkVec(-1, 4'b0001, 2, 1, 4'b0, 0, 0, 14, C_GREEN,  1, 0, 0));
    // Emergency during yellow: yellow is not cut
    vecs.push_back(mkVec(-1, 4'b0100, 11, 10, 4'b0, 0, 0, 12, C_YELLOW, 0, 0, 0));
    vecs.push_back(mkVec(-1, 4'b0100, 11, 10, 4'b0, 0, 0, 15, C_GREEN,  2, 0, 1));
    // Emergency aborts a walk; walk is re-served afterwards
    vecs.push_back(mkVec( 4, 4'b0010, 17, 3, 4'b0, 0, 0, 18, C_RED,   0, 0, 0));
    vecs.push_back(mkVec( 4, 4'b0010, 17, 3, 4'b0, 0, 0, 20, C_GREEN, 1, 0, 1));
    vecs.push_back(mkVec( 4, 4'b0010, 17, 3, 4'b0, 0, 0, 31, C_RED,   1, 1, 0));
    vecs.push_back(mkVec( 4, 4'b0010, 17, 3, 4'b0, 0, 0, 38, C_GREEN, 2, 0, 0));
    // Two emergencies plus pedestrian: dir0, then dir1, then walk
    vecs.push_back(mkVec( 2, 4'b0001, 2, 4, 4'b0010, 2, 19,  3, C_GREEN,  0, 0, 1));
    vecs.push_back(mkVec( 2, 4'b0001, 2, 4, 4'b0010, 2, 19,  9, C_YELLOW, 0, 0, 0));
    vecs.push_back(mkVec( 2, 4'b0001, 2, 4, 4'b0010, 2, 19, 14, C_GREEN,  1, 0, 1));
    vecs.push_back(mkVec( 2, 4'b0001, 2, 4, 4'b0010, 2, 19, 22, C_YELLOW, 1, 0, 0));
    vecs.push_back(mkVec( 2, 4'b0001, 2, 4, 4'b0010, 2, 19, 27, C_RED,    1, 1, 0));
    vecs.push_back(mkVec( 2, 4'b0001, 2, 4, 4'b0010, 2, 19, 34, C_GREEN,  2, 0, 0));

    foreach (vecs[v]) begin
      resetDut("vec_reset");
      for (int k = 0; k < vecs[v].checkCycle; k++) begin
        logic [3:0] e;
        e = 4'b0;
        if (k >= vecs[v].startA && k < vecs[v].startA + vecs[v].lenA) e = e | vecs[v].emgA;
        if (k >= vecs[v].startB && k < vecs[v].startB + vecs[v].lenB) e = e | vecs[v].emgB;
        applyStimulus(1'b0, k == vecs[v].pedCycle, e, "vec_model");
      end
      checkDirected($sformatf("vec%0d", v), vecs[v].expColor, vecs[v].expDir,
                    vecs[v].expWalk, vecs[v].expEmg);
    end

    // Reset in the middle of an emergency green drops the pending walk too
    resetDut("midrst_reset");
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, k == 4, (k >= 2) ? 4'b0001 : 4'b0, "midrst_model");
    checkDirected("midrst_in_emg", C_GREEN, 0, 0, 1);
    applyStimulus(1'b1, 1'b0, 4'b0001, "midrst_model");
    checkDirected("midrst_after", C_GREEN, 0, 0, 0);
    for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b0, 4'b0, "midrst_model");
    checkDirected("midrst_no_walk", C_GREEN, 1, 0, 0);

    // Three-way rotation wraps 2 -> 0
    resetDut("wrap_reset");
    for (int k = 0; k < 45; k++) begin
      applyStimulus(1'b0, 1'b0, 4'b0, "wrap_model");
      if (cycle == 15) check3Way("wrap_dir1", C_GREEN, 1);
      if (cycle == 30) check3Way("wrap_dir2", C_GREEN, 2);
    end
    check3Way("wrap_dir0", C_GREEN, 0);

    // Random traffic against the model
    begin
      int         hold;
      logic [3:0] e;
      hold = 0;
      e    = 4'b0;
      resetDut("rand_reset");
      for (int k = 0; k < 3000; k++) begin
        if (hold == 0) begin
          e    = ($urandom_range(0, 9) < 7) ? 4'b0 : 4'($urandom_range(1, 15));
          hold = $urandom_range(1, 25);
        end
        hold--;
        applyStimulus($urandom_range(0, 499) == 0, $urandom_range(0, 15) == 0, e, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
